msx_bus_wait_arbiter: RTL and testbench

//  Owns the cartridge data-bus drive and WAIT_n for each MSX read or write strobe.

---
 rtl/msx_bus_wait_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_msx_bus_wait_arbiter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/msx_bus_wait_arbiter.sv
// MSX cartridge bus arbiter: grants one device per RD/WR strobe, holds the Z80
// in WAIT until that device acknowledges, then drives read data until strobe end.
module msx_bus_wait_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 255,
    parameter int TMO_W   = 8
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 BUS_RD_n,
    input  logic                 BUS_WR_n,
    input  logic [NUM_REQ-1:0]   REQ,
    input  logic [NUM_REQ-1:0]   ACK,
    input  logic [8*NUM_REQ-1:0] RDATA,
    output logic [NUM_REQ-1:0]   GNT,
    output logic                 IS_READ,
    output logic [7:0]           DOUT,
    output logic                 BUSDIR_n,
    output logic                 WAIT_n,
    output logic                 CONFLICT,
    output logic                 TIMEOUT_ERR
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_HOLD,
        ST_SKIP
    } state_t;

    state_t             state_q, state_d;
    logic               strobe_q;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [PW-1:0]      gidx_q, gidx_d;
    logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [TMO_W-1:0]   cnt_q, cnt_d;
    logic               is_read_q, is_read_d;
    logic [7:0]         dout_q, dout_d;
    logic               busdir_n_q, busdir_n_d;
    logic               wait_n_q, wait_n_d;
    logic               conflict_q, conflict_d;
    logic               tmo_err_q, tmo_err_d;

    logic               strobe, start, rd;
    logic               pick_found;
    logic [PW-1:0]      pick_idx;
    int                 req_cnt;
    int                 j;
    logic               rel;
    logic [7:0]         rdata_sel;
    logic [PW-1:0]      rr_next;

    assign strobe    = !BUS_RD_n || !BUS_WR_n;
    assign start     = strobe && !strobe_q;
    assign rd        = !BUS_RD_n;
    assign rdata_sel = RDATA[8*int'(gidx_q) +: 8];
    assign rr_next   = (gidx_q == PW'(NUM_REQ - 1)) ? '0 : gidx_q + PW'(1);

    // Round-robin search starting at rr_ptr, plus popcount for conflict.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        req_cnt    = 0;
        j          = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = int'(rr_ptr_q) + i;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!pick_found && REQ[j]) begin
                pick_found = 1'b1;
                pick_idx   = PW'(j);
            end
            if (REQ[i]) req_cnt = req_cnt + 1;
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        gidx_d     = gidx_q;
        rr_ptr_d   = rr_ptr_q;
        cnt_d      = cnt_q;
        is_read_d  = is_read_q;
        dout_d     = dout_q;
        busdir_n_d = busdir_n_q;
        wait_n_d   = wait_n_q;
        conflict_d = 1'b0;
        tmo_err_d  = 1'b0;
        rel        = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (pick_found) begin
                        state_d    = ST_WAIT;
                        gnt_d      = NUM_REQ'(1) << pick_idx;
                        gidx_d     = pick_idx;
                        is_read_d  = rd;
                        wait_n_d   = 1'b0;
                        busdir_n_d = !rd;
                        cnt_d      = '0;
                        conflict_d = (req_cnt > 1);
                    end else begin
                        state_d = ST_SKIP;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q + TMO_W'(1);
                // ACK beats a same-cycle timeout.
                if (ACK[gidx_q]) begin
                    wait_n_d = 1'b1;
                    if (is_read_q) dout_d = rdata_sel;
                    state_d = ST_HOLD;
                end else if (cnt_q == TMO_LAST) begin
                    wait_n_d  = 1'b1;
                    dout_d    = 8'hFF;
                    tmo_err_d = 1'b1;
                    state_d   = ST_HOLD;
                end else if (!strobe) begin
                    rel = 1'b1;
                end
            end
            ST_HOLD: begin
                if (!strobe) rel = 1'b1;
            end
            ST_SKIP: begin
                if (!strobe) state_d = ST_IDLE;
            end
        endcase

        if (rel) begin
            state_d    = ST_IDLE;
            gnt_d      = '0;
            busdir_n_d = 1'b1;
            is_read_d  = 1'b0;
            dout_d     = 8'hFF;
            wait_n_d   = 1'b1;
            rr_ptr_d   = rr_next;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            strobe_q   <= 1'b0;
            gnt_q      <= '0;
            gidx_q     <= '0;
            rr_ptr_q   <= '0;
            cnt_q      <= '0;
            is_read_q  <= 1'b0;
            dout_q     <= 8'hFF;
            busdir_n_q <= 1'b1;
            wait_n_q   <= 1'b1;
            conflict_q <= 1'b0;
            tmo_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            strobe_q   <= strobe;
            gnt_q      <= gnt_d;
            gidx_q     <= gidx_d;
            rr_ptr_q   <= rr_ptr_d;
            cnt_q      <= cnt_d;
            is_read_q  <= is_read_d;
            dout_q     <= dout_d;
            busdir_n_q <= busdir_n_d;
            wait_n_q   <= wait_n_d;
            conflict_q <= conflict_d;
            tmo_err_q  <= tmo_err_d;
        end
    end

    assign GNT         = gnt_q;
    assign IS_READ     = is_read_q;
    assign DOUT        = dout_q;
    assign BUSDIR_n    = busdir_n_q;
    assign WAIT_n      = wait_n_q;
    assign CONFLICT    = conflict_q;
    assign TIMEOUT_ERR = tmo_err_q;

endmodule

// File: tb/tb_msx_bus_wait_arbiter.sv
// Directed bench for msx_bus_wait_arbiter: grant order, WAIT length,
// read data, timeout, skip/abort and reset behaviour.
module tb_msx_bus_wait_arbiter;

    localparam int NR = 4;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          BUS_RD_n, BUS_WR_n;
    logic [NR-1:0] REQ, ACK;
    logic [8*NR-1:0] RDATA;
    logic [NR-1:0] GNT;
    logic          IS_READ, BUSDIR_n, WAIT_n, CONFLICT, TIMEOUT_ERR;
    logic [7:0]    DOUT;

    int n_checks = 0;
    int n_fail   = 0;
    int low_cnt;
    int tmo_cnt;
    int conf_cnt;
    bit done;

    msx_bus_wait_arbiter #(.NUM_REQ(NR), .TIMEOUT(16), .TMO_W(8)) dut (
        .CLK(CLK), .RESET(RESET), .BUS_RD_n(BUS_RD_n), .BUS_WR_n(BUS_WR_n),
        .REQ(REQ), .ACK(ACK), .RDATA(RDATA), .GNT(GNT), .IS_READ(IS_READ),
        .DOUT(DOUT), .BUSDIR_n(BUSDIR_n), .WAIT_n(WAIT_n),
        .CONFLICT(CONFLICT), .TIMEOUT_ERR(TIMEOUT_ERR)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".gnt"}, 32'(GNT), 0);
        chk({tag, ".wait_n"}, 32'(WAIT_n), 1);
        chk({tag, ".busdir_n"}, 32'(BUSDIR_n), 1);
        chk({tag, ".dout"}, 32'(DOUT), 'hFF);
        chk({tag, ".is_read"}, 32'(IS_READ), 0);
    endtask

    initial begin
        RESET = 1'b1; BUS_RD_n = 1'b1; BUS_WR_n = 1'b1;
        REQ = '0; ACK = '0;
        RDATA = 32'h33_44_A5_11;
        tick(); tick();
        chk_idle("reset");
        chk("reset.conflict", 32'(CONFLICT), 0);
        chk("reset.tmo_err", 32'(TIMEOUT_ERR), 0);
        RESET = 1'b0;
        tick();

        // T3: four reads, all requesting -> rotating grants
        conf_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            BUS_RD_n = 1'b0; REQ = 4'b1111;
            tick();
            chk($sformatf("t3.gnt%0d", i), 32'(GNT), 32'(1 << i));
            if (CONFLICT) conf_cnt++;
            ACK = 4'(1 << i);
            tick();
            if (CONFLICT) conf_cnt++;
            chk($sformatf("t3.dout%0d", i), 32'(DOUT), 32'(RDATA[8*i +: 8]));
            chk($sformatf("t3.wait%0d", i), 32'(WAIT_n), 1);
            ACK = '0; REQ = '0; BUS_RD_n = 1'b1;
            tick();
            chk_idle($sformatf("t3.rel%0d", i));
        end
        chk("t3.conflicts", 32'(conf_cnt), 4);

        // T1: single read, ACK after three wait cycles
        BUS_RD_n = 1'b0; REQ = 4'b0010;
        tick();
        chk("t1.gnt", 32'(GNT), 'b0010);
        chk("t1.busdir", 32'(BUSDIR_n), 0);
        chk("t1.is_read", 32'(IS_READ), 1);
        chk("t1.conflict", 32'(CONFLICT), 0);
        low_cnt = 1;
        tick(); if (!WAIT_n) low_cnt++;
        tick(); if (!WAIT_n) low_cnt++;
        tick(); if (!WAIT_n) low_cnt++;
        ACK = 4'b0010;
        tick(); if (!WAIT_n) low_cnt++;
        chk("t1.wait_len", 32'(low_cnt), 4);
        chk("t1.dout", 32'(DOUT), 'hA5);
        ACK = '0; REQ = '0;
        tick();
        chk("t1.hold_dout", 32'(DOUT), 'hA5);
        chk("t1.hold_busdir", 32'(BUSDIR_n), 0);
        chk("t1.hold_gnt", 32'(GNT), 'b0010);
        BUS_RD_n = 1'b1;
        tick();
        chk_idle("t1.rel");

        // T2: write with immediate ACK; rr pointer at 2 wraps to device 0
        BUS_WR_n = 1'b0; REQ = 4'b0001; ACK = 4'b0001;
        tick();
        chk("t2.gnt", 32'(GNT), 'b0001);
        chk("t2.wait_lo", 32'(WAIT_n), 0);
        chk("t2.busdir", 32'(BUSDIR_n), 1);
        chk("t2.is_read", 32'(IS_READ), 0);
        tick();
        chk("t2.wait_hi", 32'(WAIT_n), 1);
        chk("t2.dout", 32'(DOUT), 'hFF);
        chk("t2.busdir2", 32'(BUSDIR_n), 1);
        ACK = '0; REQ = '0; BUS_WR_n = 1'b1;
        tick();
        chk_idle("t2.rel");

        // T4: read with no ACK -> timeout after 16 WAIT cycles
        BUS_RD_n = 1'b0; REQ = 4'b0100;
        tick();
        chk("t4.gnt", 32'(GNT), 'b0100);
        low_cnt = WAIT_n ? 0 : 1;
        tmo_cnt = 0;
        done = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            tick();
            if (TIMEOUT_ERR) tmo_cnt++;
            if (!WAIT_n) low_cnt++;
            else done = 1'b1;
        end
        chk("t4.bounded", 32'(done), 1);
        chk("t4.wait_len", 32'(low_cnt), 16);
        chk("t4.dout", 32'(DOUT), 'hFF);
        tick();
        if (TIMEOUT_ERR) tmo_cnt++;
        chk("t4.tmo_pulses", 32'(tmo_cnt), 1);
        chk("t4.hold_busdir", 32'(BUSDIR_n), 0);
        REQ = '0; BUS_RD_n = 1'b1;
        tick();
        chk_idle("t4.rel");

        // T5: read nobody claims; late REQ ignored in SKIP
        BUS_RD_n = 1'b0;
        tick();
        chk_idle("t5.skip");
        REQ = 4'b0010;
        tick();
        chk("t5.late_req", 32'(GNT), 0);
        chk("t5.late_wait", 32'(WAIT_n), 1);
        BUS_RD_n = 1'b1; REQ = '0;
        tick();

        // Aborted read: strobe released while waiting
        BUS_RD_n = 1'b0; REQ = 4'b0010;
        tick();
        chk("t5.abort_gnt", 32'(GNT), 'b0010);
        tick();
        BUS_RD_n = 1'b1; REQ = '0;
        tick();
        chk_idle("t5.abort");
        chk("t5.abort_tmo", 32'(TIMEOUT_ERR), 0);

        // T6: reset mid-WAIT; rr pointer was 2 after abort of device 1
        BUS_RD_n = 1'b0; REQ = 4'b1111;
        tick();
        chk("t6.gnt", 32'(GNT), 'b0100);
        chk("t6.busdir", 32'(BUSDIR_n), 0);
        RESET = 1'b1; BUS_RD_n = 1'b1; REQ = '0;
        tick();
        chk_idle("t6.reset");
        chk("t6.conflict", 32'(CONFLICT), 0);
        RESET = 1'b0;
        tick();
        BUS_RD_n = 1'b0; REQ = 4'b1111;
        tick();
        chk("t6.rr_reset", 32'(GNT), 'b0001);
        BUS_RD_n = 1'b1; REQ = '0;
        tick();
        chk_idle("t6.rel");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
